// File: rtl/if_pkg.sv
// if_pkg: shared constants and byte-lane assembly for the fetch stage
package if_pkg;
    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP = 32'h0;

    // b0 is the byte at the lowest address
    function automatic logic [INSTR_W-1:0] assemble(
        input logic [7:0] b0,
        input logic [7:0] b1,
        input logic [7:0] b2,
        input logic [7:0] b3,
        input bit         big
    );
        return big ? {b0, b1, b2, b3} : {b3, b2, b1, b0};
    endfunction
endpackage

// File: rtl/if_imem.sv
// if_imem: byte-addressed instruction memory, sync byte write, comb word read
module if_imem
    import if_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int IMEM_BYTES = 64,
    parameter bit BIG_ENDIAN = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               we,
    input  logic [XLEN-1:0]    waddr,
    input  logic [7:0]         wdata,
    input  logic [XLEN-1:0]    raddr,
    output logic [INSTR_W-1:0] rdata,
    output logic               oor
);
    localparam int AW = (IMEM_BYTES > 1) ? $clog2(IMEM_BYTES) : 1;

    logic [7:0]    mem [IMEM_BYTES];
    logic [AW-1:0] ra;

    // Program-load write; a write coinciding with reset is dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n && we && waddr < XLEN'(IMEM_BYTES))
            mem[waddr[AW-1:0]] <= wdata;
    end

    // Word read; comparing against IMEM_BYTES-3 avoids overflow of raddr+3
    always_comb begin
        ra    = raddr[AW-1:0];
        oor   = raddr >= XLEN'(IMEM_BYTES - 3);
        rdata = oor ? NOP : assemble(mem[ra], mem[ra + AW'(1)], mem[ra + AW'(2)],
                                     mem[ra + AW'(3)], BIG_ENDIAN);
    end
endmodule

// File: rtl/if_stage_pipe.sv
// if_stage_pipe: PC register, instruction memory and IF/ID pipeline register
module if_stage_pipe
    import if_pkg::*;
#(
    parameter int          XLEN       = 32,
    parameter int          IMEM_BYTES = 64,
    parameter logic [31:0] RESET_PC   = 32'h0,
    parameter bit          BIG_ENDIAN = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               PC_write,
    input  logic               redirect,
    input  logic [XLEN-1:0]    redirect_pc,
    input  logic               flush,
    input  logic               load_en,
    input  logic [XLEN-1:0]    load_addr,
    input  logic [7:0]         load_data,
    output logic [XLEN-1:0]    pc,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [XLEN-1:0]    ifid_pc,
    output logic [XLEN-1:0]    ifid_pc4,
    output logic               ifid_valid,
    output logic               ifid_fault,
    output logic               misalign_err
);
    logic [XLEN-1:0]    pc_q, pc_d, ifid_pc_q, ifid_pc_d, ifid_pc4_q, ifid_pc4_d;
    logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d, fetch_word;
    logic               ifid_valid_q, ifid_valid_d, ifid_fault_q, ifid_fault_d;
    logic               misalign_q, misalign_d, fetch_oor, kill;

    if_imem #(.XLEN(XLEN), .IMEM_BYTES(IMEM_BYTES), .BIG_ENDIAN(BIG_ENDIAN)) u_imem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (load_en),
        .waddr (load_addr),
        .wdata (load_data),
        .raddr (pc_q),
        .rdata (fetch_word),
        .oor   (fetch_oor)
    );

    // Next PC and IF/ID contents; redirect/flush override a stall
    always_comb begin
        kill         = redirect | flush;
        pc_d         = redirect ? {redirect_pc[XLEN-1:2], 2'b00} : PC_write ? pc_q + XLEN'(4) : pc_q;
        misalign_d   = redirect & |redirect_pc[1:0];
        ifid_instr_d = kill ? NOP : PC_write ? fetch_word : ifid_instr_q;
        ifid_pc_d    = kill ? '0 : PC_write ? pc_q : ifid_pc_q;
        ifid_pc4_d   = kill ? '0 : PC_write ? pc_q + XLEN'(4) : ifid_pc4_q;
        ifid_valid_d = kill ? 1'b0 : PC_write ? 1'b1 : ifid_valid_q;
        ifid_fault_d = kill ? 1'b0 : PC_write ? fetch_oor : ifid_fault_q;
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= XLEN'(RESET_PC);
            ifid_instr_q <= NOP;
            ifid_pc_q    <= '0;
            ifid_pc4_q   <= '0;
            ifid_valid_q <= 1'b0;
            ifid_fault_q <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_fault_q <= ifid_fault_d;
            misalign_q   <= misalign_d;
        end
    end

    assign pc           = pc_q;
    assign ifid_instr   = ifid_instr_q;
    assign ifid_pc      = ifid_pc_q;
    assign ifid_pc4     = ifid_pc4_q;
    assign ifid_valid   = ifid_valid_q;
    assign ifid_fault   = ifid_fault_q;
    assign misalign_err = misalign_q;
endmodule

// File: tb/tb_if_stage_pipe.sv
// tb_if_stage_pipe: randomized and directed checks against a reference model
module tb_if_stage_pipe;
    logic        clk = 0, rst_n = 1;
    logic        PC_write = 0, redirect = 0, flush = 0, load_en = 0;
    logic [31:0] redirect_pc = 0, load_addr = 0;
    logic [7:0]  load_data = 0;
    logic [31:0] pc, ifid_instr, ifid_pc, ifid_pc4;
    logic        ifid_valid, ifid_fault, misalign_err;
    logic [31:0] le_pc, le_instr, le_ipc, le_ipc4;
    logic        le_valid, le_fault, le_mis;

    logic [31:0] m_pc, m_be, m_le, m_ipc, m_ipc4;
    logic        m_valid, m_fault, m_mis;
    logic [7:0]  m_mem [64];
    int checks = 0, errors = 0;

    logic [31:0] exp_be [4] = '{32'h08410002, 32'h00213002, 32'h0C260002, 32'h00E64000};
    logic [31:0] exp_le [4] = '{32'h02004108, 32'h02302100, 32'h0200260C, 32'h0040E600};
    logic [7:0]  prog [16] = '{8'h08, 8'h41, 8'h00, 8'h02, 8'h00, 8'h21, 8'h30, 8'h02,
                               8'h0C, 8'h26, 8'h00, 8'h02, 8'h00, 8'hE6, 8'h40, 8'h00};

    wire [162:0] dut_v = {pc, ifid_instr, le_instr, ifid_pc, ifid_pc4, ifid_valid, ifid_fault, misalign_err};
    wire [162:0] mod_v = {m_pc, m_be, m_le, m_ipc, m_ipc4, m_valid, m_fault, m_mis};

    always #5 clk = ~clk;

    if_stage_pipe #(.BIG_ENDIAN(1)) dut (
        .clk(clk), .rst_n(rst_n), .PC_write(PC_write), .redirect(redirect),
        .redirect_pc(redirect_pc), .flush(flush), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .pc(pc), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc),
        .ifid_pc4(ifid_pc4), .ifid_valid(ifid_valid), .ifid_fault(ifid_fault),
        .misalign_err(misalign_err)
    );

    if_stage_pipe #(.BIG_ENDIAN(0)) dut_le (
        .clk(clk), .rst_n(rst_n), .PC_write(PC_write), .redirect(redirect),
        .redirect_pc(redirect_pc), .flush(flush), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .pc(le_pc), .ifid_instr(le_instr), .ifid_pc(le_ipc),
        .ifid_pc4(le_ipc4), .ifid_valid(le_valid), .ifid_fault(le_fault),
        .misalign_err(le_mis)
    );

    // Reference fetch: word at a, NOP when any of its four bytes is past the memory
    function automatic logic [31:0] m_fetch(input logic [31:0] a, input bit big);
        logic [31:0] w = 0;
        if (64'(a) + 3 >= 64) return 32'h0;
        for (int k = 0; k < 4; k++)
            w = big ? {w[23:0], m_mem[a + k]} : {m_mem[a + k], w[31:8]};
        return w;
    endfunction

    task automatic model_reset();
        m_pc = 0; m_be = 0; m_le = 0; m_ipc = 0; m_ipc4 = 0;
        m_valid = 0; m_fault = 0; m_mis = 0;
    endtask

    // Drive one cycle of inputs, advance the model at the edge, return at the next negedge
    task automatic step(input bit pw, input bit r, input bit fl, input logic [31:0] rpc,
                        input bit le, input logic [31:0] la, input logic [7:0] ld);
        logic [31:0] wbe, wle;
        bit          f;
        PC_write = pw; redirect = r; flush = fl; redirect_pc = rpc;
        load_en = le; load_addr = la; load_data = ld;
        @(posedge clk);
        if (rst_n) begin
            f   = 64'(m_pc) + 3 >= 64;
            wbe = m_fetch(m_pc, 1);
            wle = m_fetch(m_pc, 0);
            if (r || fl) begin
                m_valid = 0; m_be = 0; m_le = 0; m_ipc = 0; m_ipc4 = 0; m_fault = 0;
            end else if (pw) begin
                m_valid = 1; m_be = wbe; m_le = wle; m_ipc = m_pc; m_ipc4 = m_pc + 4; m_fault = f;
            end
            m_mis = r && rpc[1:0] != 0;
            m_pc  = r ? {rpc[31:2], 2'b00} : pw ? m_pc + 4 : m_pc;
            if (le && la < 64) m_mem[la[5:0]] = ld;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1 rst_n = 0;
        model_reset();
        #1;
        checks++;
        if (dut_v !== mod_v) begin
            errors++; $display("FAIL reset: got %h want %h", dut_v, mod_v);
        end
        @(negedge clk);
        checks++;
        if (pc !== 32'h0 || ifid_valid !== 1'b0) begin
            errors++; $display("FAIL reset_hold: pc=%h valid=%b want 0/0", pc, ifid_valid);
        end
        rst_n = 1;
    endtask

    task automatic test_preload();
        for (int i = 0; i < 64; i++) begin
            step(0, 0, 0, 0, 1, i, 8'($urandom));
            checks++;
            if (dut_v !== mod_v) begin
                errors++; $display("FAIL preload[%0d]: got %h want %h", i, dut_v, mod_v);
            end
        end
    endtask

    task automatic test_program();
        for (int i = 0; i < 16; i++) step(0, 0, 0, 0, 1, i, prog[i]);
        rst_n = 0;
        model_reset();
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 2; i++) begin
            step(1, 0, 0, 0, 0, 0, 0);
            checks++;
            if (dut_v !== mod_v || ifid_instr !== exp_be[i] || le_instr !== exp_le[i] ||
                ifid_pc !== 32'(4 * i) || ifid_valid !== 1'b1) begin
                errors++;
                $display("FAIL program[%0d]: instr=%h le=%h pc=%h valid=%b want %h %h %h 1",
                         i, ifid_instr, le_instr, ifid_pc, ifid_valid, exp_be[i], exp_le[i], 4 * i);
            end
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 0, 0, 0, 0, 0);
            checks++;
            if (dut_v !== mod_v || pc !== 32'h8 || ifid_instr !== exp_be[1] || ifid_pc !== 32'h4) begin
                errors++;
                $display("FAIL stall[%0d]: pc=%h instr=%h ipc=%h want 8 %h 4", i, pc, ifid_instr, ifid_pc, exp_be[1]);
            end
        end
        for (int i = 2; i < 4; i++) begin
            step(1, 0, 0, 0, 0, 0, 0);
            checks++;
            if (dut_v !== mod_v || ifid_instr !== exp_be[i] || ifid_pc !== 32'(4 * i)) begin
                errors++;
                $display("FAIL resume[%0d]: instr=%h ipc=%h want %h %h", i, ifid_instr, ifid_pc, exp_be[i], 4 * i);
            end
        end
    endtask

    task automatic test_redirect_stall();
        step(0, 1, 0, 32'h4, 0, 0, 0);
        checks++;
        if (dut_v !== mod_v || pc !== 32'h4 || ifid_valid !== 1'b0 || ifid_instr !== 32'h0) begin
            errors++;
            $display("FAIL redirect_stall: pc=%h valid=%b instr=%h want 4 0 0", pc, ifid_valid, ifid_instr);
        end
        step(1, 0, 0, 0, 0, 0, 0);
        checks++;
        if (dut_v !== mod_v || ifid_instr !== exp_be[1] || ifid_valid !== 1'b1) begin
            errors++; $display("FAIL redirect_next: instr=%h want %h", ifid_instr, exp_be[1]);
        end
    endtask

    task automatic test_misalign();
        step(1, 1, 0, 32'h6, 0, 0, 0);
        checks++;
        if (dut_v !== mod_v || pc !== 32'h4 || misalign_err !== 1'b1) begin
            errors++; $display("FAIL misalign: pc=%h err=%b want 4 1", pc, misalign_err);
        end
        step(1, 0, 0, 0, 0, 0, 0);
        checks++;
        if (dut_v !== mod_v || misalign_err !== 1'b0) begin
            errors++; $display("FAIL misalign_pulse: err=%b want 0", misalign_err);
        end
    endtask

    task automatic test_flush();
        step(1, 0, 1, 0, 0, 0, 0);
        checks++;
        if (dut_v !== mod_v || ifid_valid !== 1'b0 || ifid_instr !== 32'h0) begin
            errors++; $display("FAIL flush: got %h want %h", dut_v, mod_v);
        end
    endtask

    task automatic test_out_of_range();
        step(0, 1, 0, 32'd60, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        checks++;
        if (dut_v !== mod_v || ifid_fault !== 1'b0 || ifid_valid !== 1'b1) begin
            errors++; $display("FAIL last_word: fault=%b valid=%b want 0 1", ifid_fault, ifid_valid);
        end
        step(1, 0, 0, 0, 1, 32'd70, 8'hAA);
        checks++;
        if (dut_v !== mod_v || ifid_instr !== 32'h0 || ifid_fault !== 1'b1 || ifid_valid !== 1'b1) begin
            errors++;
            $display("FAIL oor: instr=%h fault=%b valid=%b want 0 1 1", ifid_instr, ifid_fault, ifid_valid);
        end
        step(0, 1, 0, 32'h4, 1, 32'd64, 8'h55);
        step(1, 0, 0, 0, 0, 0, 0);
        checks++;
        if (dut_v !== mod_v || ifid_instr !== exp_be[1]) begin
            errors++; $display("FAIL oor_write_ignored: instr=%h want %h", ifid_instr, exp_be[1]);
        end
    endtask

    task automatic test_wrap();
        step(0, 1, 0, 32'hFFFF_FFFE, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        checks++;
        if (dut_v !== mod_v || pc !== 32'h0 || ifid_fault !== 1'b1 || ifid_pc4 !== 32'h0) begin
            errors++; $display("FAIL wrap: pc=%h fault=%b pc4=%h want 0 1 0", pc, ifid_fault, ifid_pc4);
        end
    endtask

    task automatic test_async_reset();
        step(1, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #2 rst_n = 0;
        model_reset();
        #1;
        checks++;
        if (dut_v !== mod_v || pc !== 32'h0 || ifid_valid !== 1'b0) begin
            errors++; $display("FAIL async_reset: pc=%h valid=%b want 0 0", pc, ifid_valid);
        end
        step(0, 0, 0, 0, 1, 0, 8'hFF);
        rst_n = 1;
        step(1, 0, 0, 0, 0, 0, 0);
        checks++;
        if (dut_v !== mod_v || ifid_instr !== exp_be[0] || le_instr !== exp_le[0]) begin
            errors++;
            $display("FAIL reset_drops_load: instr=%h le=%h want %h %h", ifid_instr, le_instr, exp_be[0], exp_le[0]);
        end
    endtask

    task automatic test_random();
        logic [31:0] rpc;
        for (int i = 0; i < 400; i++) begin
            rpc = ($urandom % 16 == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : 32'($urandom_range(0, 80));
            step($urandom_range(0, 3) != 0, $urandom % 8 == 0, $urandom % 10 == 0, rpc,
                 $urandom % 6 == 0, 32'($urandom_range(0, 79)), 8'($urandom));
            checks++;
            if (dut_v !== mod_v) begin
                errors++; $display("FAIL random[%0d]: got %h want %h", i, dut_v, mod_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_preload();
        test_program();
        test_stall();
        test_redirect_stall();
        test_misalign();
        test_flush();
        test_out_of_range();
        test_wrap();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
